// File: rtl/scan_pkg.sv
// Shared types and constants for the scanner buffers and the downlink flush controller.
package scan_pkg;

    localparam int unsigned MEM_W           = 8;
    // Full level; the scanners' 80/90/100 thresholds are derived from the same value.
    localparam int unsigned MEM_MAX_DEFAULT = 100;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        DRAIN,
        REPORT
    } flush_state_t;

endpackage

// File: rtl/scan_flush_arb.sv
// Two-way picker: full scanners beat ready-only scanners, ties go to the one not served last.
module scan_flush_arb (
    input  logic [1:0] req,
    input  logic [1:0] full,
    input  logic       rr_last,
    output logic       grant_valid,
    output logic       grant_idx
);

    logic [1:0] cand;

    always_comb begin
        cand        = (|full) ? full : req;
        grant_valid = |req;
        if (cand == 2'b11) begin
            grant_idx = ~rr_last;
        end else begin
            grant_idx = cand[1];
        end
    end

endmodule

// File: rtl/scan_flush_ctrl.sv
// Downlink-side flush controller: grants one scanner, watches its buffer drain to zero and
// emits one transfer record with the total drained.
import scan_pkg::*;

module scan_flush_ctrl #(
    parameter int unsigned MEM_MAX = MEM_MAX_DEFAULT,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             link_en,
    input  logic [1:0]       rdy_flush_i,
    input  logic [MEM_W-1:0] mem_used0_i,
    input  logic [MEM_W-1:0] mem_used1_i,
    output logic [1:0]       flush_o,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_src,
    output logic [CNT_W-1:0] tx_count,
    output logic             busy,
    output logic             err_timeout
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT) + 1;
    localparam int unsigned SUM_W = ((CNT_W > MEM_W) ? CNT_W : MEM_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};

    flush_state_t     state_q, state_d;
    logic             sel_q, sel_d;
    logic             rr_last_q, rr_last_d;
    logic [MEM_W-1:0] level_q, level_d;
    logic [MEM_W-1:0] prev_q, prev_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;

    logic [1:0]       full;
    logic [1:0]       req;
    logic             grant_valid;
    logic             grant_idx;
    logic [MEM_W-1:0] cur;
    logic [MEM_W-1:0] sub_a;
    logic [MEM_W-1:0] diff;
    logic [SUM_W-1:0] acc;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] count_sat;

    assign full[0] = (mem_used0_i >= MEM_W'(MEM_MAX));
    assign full[1] = (mem_used1_i >= MEM_W'(MEM_MAX));
    assign req     = rdy_flush_i | full;

    scan_flush_arb u_arb (
        .req         (req),
        .full        (full),
        .rr_last     (rr_last_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign cur = sel_q ? mem_used1_i : mem_used0_i;

    // First drop in FLUSH starts the total from zero; DRAIN accumulates on top of it.
    always_comb begin
        sub_a     = (state_q == FLUSH) ? level_q : prev_q;
        diff      = sub_a - cur;
        acc       = (state_q == FLUSH) ? '0 : SUM_W'(count_q);
        sum       = acc + SUM_W'(diff);
        count_sat = (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rr_last_d = rr_last_q;
        level_d   = level_q;
        prev_d    = prev_q;
        count_d   = count_q;
        tmo_d     = tmo_q;
        err_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (link_en && grant_valid) begin
                    state_d   = FLUSH;
                    sel_d     = grant_idx;
                    rr_last_d = grant_idx;
                    level_d   = grant_idx ? mem_used1_i : mem_used0_i;
                    count_d   = '0;
                    tmo_d     = '0;
                end
            end
            FLUSH: begin
                if (cur < level_q) begin
                    state_d = DRAIN;
                    prev_d  = cur;
                    count_d = count_sat;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            DRAIN: begin
                // Rises in the level are ignored; only drops below the last seen value count.
                if (cur < prev_q) begin
                    count_d = count_sat;
                    prev_d  = cur;
                end
                if (cur == '0) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                if (tx_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            rr_last_q <= 1'b1;
            level_q   <= '0;
            prev_q    <= '0;
            count_q   <= '0;
            tmo_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            rr_last_q <= rr_last_d;
            level_q   <= level_d;
            prev_q    <= prev_d;
            count_q   <= count_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        flush_o = 2'b00;
        if (state_q == FLUSH) begin
            flush_o[sel_q] = 1'b1;
        end
    end

    assign tx_valid    = (state_q == REPORT);
    assign tx_src      = sel_q;
    assign tx_count    = count_q;
    assign busy        = (state_q != IDLE);
    assign err_timeout = err_q;

endmodule

// File: tb/tb_scan_flush_ctrl.sv
// Directed bench for scan_flush_ctrl: arbitration order, drain accounting, timeout, back-pressure
// and reset behaviour.
module tb_scan_flush_ctrl;

    logic       clk;
    logic       reset;
    logic       link_en;
    logic [1:0] rdy_flush_i;
    logic [7:0] mem_used0_i;
    logic [7:0] mem_used1_i;
    logic [1:0] flush_o;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_src;
    logic [7:0] tx_count;
    logic       busy;
    logic       err_timeout;

    int n_chk = 0;
    int n_err = 0;

    scan_flush_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .link_en     (link_en),
        .rdy_flush_i (rdy_flush_i),
        .mem_used0_i (mem_used0_i),
        .mem_used1_i (mem_used1_i),
        .flush_o     (flush_o),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_src      (tx_src),
        .tx_count    (tx_count),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mem(input int idx, input int val);
        if (idx == 0) mem_used0_i = 8'(val);
        else          mem_used1_i = 8'(val);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        rdy_flush_i = 2'b00;
        link_en     = 1'b1;
        tx_ready    = 1'b1;
        mem_used0_i = 8'd0;
        mem_used1_i = 8'd0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Drains scanner idx from start in steps of 20, then checks the record and handshake.
    task automatic drain_and_report(input int idx, input int start, input int hold);
        int v;
        v = start;
        while (v > 0) begin
            v = (v > 20) ? v - 20 : 0;
            set_mem(idx, v);
            step();
        end
        for (int k = 0; k < 8 && tx_valid !== 1'b1; k++) step();
        check("rpt_valid", 32'(tx_valid), 32'd1);
        check("rpt_src", 32'(tx_src), 32'(idx));
        check("rpt_count", 32'(tx_count), 32'(start));
        if (hold > 0) begin
            tx_ready = 1'b0;
            for (int k = 0; k < hold; k++) begin
                step();
                check("hold_valid", 32'(tx_valid), 32'd1);
                check("hold_count", 32'(tx_count), 32'(start));
            end
            tx_ready = 1'b1;
        end
        step();
        check("post_busy", 32'(busy), 32'd0);
        check("post_valid", 32'(tx_valid), 32'd0);
    endtask

    initial begin
        do_reset();
        check("rst_flush", 32'(flush_o), 32'd0);
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        check("rst_count", 32'(tx_count), 32'd0);
        check("rst_src", 32'(tx_src), 32'd0);

        // 1: single ready scanner, drain with a transient rise that must not be counted.
        rdy_flush_i = 2'b01;
        mem_used0_i = 8'd85;
        step();
        check("t1_flush", 32'(flush_o), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        rdy_flush_i = 2'b00;
        mem_used0_i = 8'd80;
        step();
        check("t1_flush_off", 32'(flush_o), 32'd0);
        mem_used0_i = 8'd60;
        step();
        mem_used0_i = 8'd70;
        step();
        mem_used0_i = 8'd30;
        step();
        check("t1_no_rpt", 32'(tx_valid), 32'd0);
        mem_used0_i = 8'd0;
        step();
        check("t1_valid", 32'(tx_valid), 32'd1);
        check("t1_src", 32'(tx_src), 32'd0);
        check("t1_count", 32'(tx_count), 32'd85);
        step();
        check("t1_idle", 32'(busy), 32'd0);

        // 2: full scanner 1 beats ready-only scanner 0.
        do_reset();
        rdy_flush_i = 2'b11;
        mem_used0_i = 8'd85;
        mem_used1_i = 8'd100;
        step();
        check("t2_grant1", 32'(flush_o), 32'd2);
        rdy_flush_i = 2'b01;
        drain_and_report(1, 100, 0);
        step();
        check("t2_grant0", 32'(flush_o), 32'd1);
        rdy_flush_i = 2'b00;
        drain_and_report(0, 85, 0);

        // 3: equal class round-robin, 0 then 1 then 0.
        do_reset();
        rdy_flush_i = 2'b11;
        mem_used0_i = 8'd85;
        mem_used1_i = 8'd85;
        step();
        check("t3_g0", 32'(flush_o), 32'd1);
        drain_and_report(0, 85, 0);
        step();
        check("t3_g1", 32'(flush_o), 32'd2);
        drain_and_report(1, 85, 0);
        mem_used0_i = 8'd85;
        step();
        check("t3_g2", 32'(flush_o), 32'd1);
        rdy_flush_i = 2'b00;

        // 4: no drop for TIMEOUT cycles aborts without a record.
        do_reset();
        rdy_flush_i = 2'b01;
        mem_used0_i = 8'd90;
        step();
        check("t4_flush", 32'(flush_o), 32'd1);
        rdy_flush_i = 2'b00;
        for (int k = 0; k < 15; k++) begin
            step();
            check("t4_hold_flush", 32'(flush_o), 32'd1);
            check("t4_no_err", 32'(err_timeout), 32'd0);
        end
        step();
        check("t4_err", 32'(err_timeout), 32'd1);
        check("t4_flush_off", 32'(flush_o), 32'd0);
        check("t4_idle", 32'(busy), 32'd0);
        check("t4_no_rpt", 32'(tx_valid), 32'd0);
        step();
        check("t4_err_pulse", 32'(err_timeout), 32'd0);
        check("t4_no_rpt2", 32'(tx_valid), 32'd0);

        // 5: back-pressure on the record.
        do_reset();
        rdy_flush_i = 2'b01;
        mem_used0_i = 8'd40;
        step();
        check("t5_flush", 32'(flush_o), 32'd1);
        rdy_flush_i = 2'b00;
        drain_and_report(0, 40, 10);

        // 6: reset mid-drain, then link_en gating of grants only.
        do_reset();
        rdy_flush_i = 2'b10;
        mem_used1_i = 8'd70;
        step();
        check("t6_flush", 32'(flush_o), 32'd2);
        rdy_flush_i = 2'b00;
        mem_used1_i = 8'd50;
        step();
        check("t6_drain", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_flush", 32'(flush_o), 32'd0);
        check("t6_rst_valid", 32'(tx_valid), 32'd0);
        check("t6_rst_count", 32'(tx_count), 32'd0);
        reset       = 1'b0;
        link_en     = 1'b0;
        rdy_flush_i = 2'b01;
        mem_used0_i = 8'd30;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t6_gated", 32'(flush_o), 32'd0);
            check("t6_gated_busy", 32'(busy), 32'd0);
        end
        link_en = 1'b1;
        step();
        check("t6_grant", 32'(flush_o), 32'd1);
        link_en     = 1'b0;
        rdy_flush_i = 2'b00;
        drain_and_report(0, 30, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
